// File: rtl/uart_echo_responder_pkg.sv
// uart_echo_responder_pkg: FSM state types, ASCII constants and the case transform.
package uart_echo_responder_pkg;
  typedef enum logic [1:0] {RX_IDLE, RX_CLEAR, RX_WAIT_LOW} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_WAIT_BUSY, TX_WAIT_DONE} tx_state_t;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
  localparam logic [7:0] ASCII_CASE_OFFSET = 8'h20;
  function automatic logic [7:0] to_upper(input logic [7:0] b);
    return (b >= ASCII_LOWER_A && b <= ASCII_LOWER_Z) ? b - ASCII_CASE_OFFSET : b;
  endfunction
endpackage

// File: rtl/uart_echo_responder_if.sv
// uart_echo_responder_if: byte-level handshake between the uart core (master) and the responder (slave).
interface uart_echo_responder_if;
  logic       rdy;
  logic [7:0] dout;
  logic       rdy_clr;
  logic       tx_busy;
  logic [7:0] din;
  logic       wr_en;
  modport master (output rdy, dout, tx_busy, input rdy_clr, din, wr_en);
  modport slave (input rdy, dout, tx_busy, output rdy_clr, din, wr_en);
endinterface

// File: rtl/uart_echo_responder_sync_fifo.sv
// uart_echo_responder_sync_fifo: single-clock FIFO with registered occupancy and asynchronous head read.
module uart_echo_responder_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] cnt_t;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  cnt_t count_q;
  logic do_push, do_pop;
  assign full    = count_q == cnt_t'(DEPTH);
  assign empty   = count_q == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q];
  assign count   = count_q;
  always_ff @(posedge clk)
    if (do_push) mem_q[wptr_q] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + cnt_t'(do_push) - cnt_t'(do_pop);
    end
  end
endmodule

// File: rtl/uart_echo_responder.sv
// uart_echo_responder: drains uart rx bytes into a FIFO and echoes them back through the uart tx.
module uart_echo_responder
  import uart_echo_responder_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter bit UPPERCASE_EN = 1,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                        clk_50m,
  input  logic                        rst,
  uart_echo_responder_if.slave        uart,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
  output logic                        overflow_o,
  output logic [7:0]                  drop_cnt_o
);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  typedef logic [TW-1:0] tmr_t;
  rx_state_t rx_q, rx_d;
  tx_state_t tx_q, tx_d;
  logic [7:0] din_q, din_d, drop_q, drop_d, rdata;
  tmr_t tmr_q, tmr_d;
  logic ovf_q, ovf_d, push, pop, drop, full, empty;
  uart_echo_responder_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_50m), .rst(rst), .push(push), .pop(pop), .wdata(uart.dout),
    .rdata(rdata), .full(full), .empty(empty), .count(fifo_count_o)
  );
  assign push         = rx_q == RX_IDLE && uart.rdy && !full;
  assign drop         = rx_q == RX_IDLE && uart.rdy && full;
  assign uart.rdy_clr = rx_q == RX_CLEAR;
  assign uart.wr_en   = tx_q == TX_LOAD;
  assign uart.din     = din_q;
  assign overflow_o   = ovf_q;
  assign drop_cnt_o   = drop_q;
  // RX_WAIT_LOW keeps a slowly falling rdy from being captured twice
  always_comb begin
    rx_d   = rx_q == RX_IDLE ? (uart.rdy ? RX_CLEAR : RX_IDLE) :
             rx_q == RX_CLEAR ? RX_WAIT_LOW : (uart.rdy ? RX_WAIT_LOW : RX_IDLE);
    ovf_d  = ovf_q | drop;
    drop_d = drop && drop_q != 8'hFF ? drop_q + 1'b1 : drop_q;
  end
  always_comb begin
    tx_d  = tx_q;
    din_d = din_q;
    tmr_d = tmr_q;
    pop   = 1'b0;
    case (tx_q)
      TX_IDLE:
        if (!empty && !uart.tx_busy) begin
          pop   = 1'b1;
          din_d = UPPERCASE_EN ? to_upper(rdata) : rdata;
          tx_d  = TX_LOAD;
        end
      TX_LOAD: begin
        tmr_d = '0;
        tx_d  = TX_WAIT_BUSY;
      end
      // a transmitter that never reports busy is given up on; the byte is not retried
      TX_WAIT_BUSY: begin
        tmr_d = tmr_q + 1'b1;
        tx_d  = uart.tx_busy ? TX_WAIT_DONE :
                tmr_q == tmr_t'(BUSY_TIMEOUT - 1) ? TX_IDLE : TX_WAIT_BUSY;
      end
      default: tx_d = uart.tx_busy ? TX_WAIT_DONE : TX_IDLE;
    endcase
  end
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      rx_q   <= RX_IDLE;
      tx_q   <= TX_IDLE;
      din_q  <= '0;
      tmr_q  <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      rx_q   <= rx_d;
      tx_q   <= tx_d;
      din_q  <= din_d;
      tmr_q  <= tmr_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end
endmodule

// File: tb/tb_uart_echo_responder.sv
// tb_uart_echo_responder: directed vectors against a behavioural uart peer with selectable tx_busy behaviour.
module tb_uart_echo_responder;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] fifo_count;
  logic overflow;
  logic [7:0] drop_cnt;
  int n_vec = 0, n_err = 0;
  int cyc = 0, clr_cnt = 0, t_rdy = 0, busy_mode = 0, bcnt = 0;
  logic [7:0] sent_q[$];
  int wr_q[$];
  logic [7:0] t2_in [6] = '{8'h61, 8'h5B, 8'h7A, 8'h60, 8'h7B, 8'h40};
  logic [7:0] t2_ex [6] = '{8'h41, 8'h5B, 8'h5A, 8'h60, 8'h7B, 8'h40};
  logic [7:0] t3_in [20] = '{8'h61, 8'h7A, 8'h00, 8'hFF, 8'h41, 8'h62, 8'h7B, 8'h60, 8'h30, 8'h6D,
                             8'h5A, 8'h71, 8'h20, 8'h80, 8'h63, 8'h7E, 8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] t3_ex [16] = '{8'h41, 8'h5A, 8'h00, 8'hFF, 8'h41, 8'h42, 8'h7B, 8'h60, 8'h30, 8'h4D,
                             8'h5A, 8'h51, 8'h20, 8'h80, 8'h43, 8'h7E};

  always #10 clk = ~clk;

  uart_echo_responder_if u_if();

  uart_echo_responder #(.FIFO_DEPTH(16), .UPPERCASE_EN(1), .BUSY_TIMEOUT(4)) dut (
    .clk_50m(clk), .rst(rst), .uart(u_if.slave),
    .fifo_count_o(fifo_count), .overflow_o(overflow), .drop_cnt_o(drop_cnt)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // tx_busy modes: 0 busy for 3 cycles after each wr_en, 1 stuck high, 2 stuck low, 3 latches high
  always @(posedge clk) begin
    case (busy_mode)
      1: begin u_if.tx_busy <= 1'b1; bcnt <= 0; end
      2: begin u_if.tx_busy <= 1'b0; bcnt <= 0; end
      3: u_if.tx_busy <= (u_if.tx_busy === 1'b1) || (u_if.wr_en === 1'b1);
      default: begin
        u_if.tx_busy <= (u_if.wr_en === 1'b1) || bcnt > 1;
        bcnt <= (u_if.wr_en === 1'b1) ? 3 : (bcnt > 0 ? bcnt - 1 : 0);
      end
    endcase
  end

  always @(negedge clk) begin
    if (u_if.wr_en === 1'b1) begin
      sent_q.push_back(u_if.din);
      wr_q.push_back(cyc);
    end
    if (u_if.rdy_clr === 1'b1) clr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rx_byte(input logic [7:0] b, input int hold);
    int lat;
    lat = -1;
    @(negedge clk);
    u_if.dout = b;
    u_if.rdy  = 1'b1;
    t_rdy = cyc;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (u_if.rdy_clr === 1'b1) begin
        lat = cyc - t_rdy;
        break;
      end
    end
    chk("rdy_clr_latency", lat, 1);
    repeat (hold) @(negedge clk);
    u_if.rdy = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int base, c0;
    rst = 1'b1;
    u_if.rdy = 1'b1;
    u_if.dout = 8'h62;
    repeat (3) @(negedge clk);
    chk("rst_rdy_clr", u_if.rdy_clr, 0);
    chk("rst_wr_en", u_if.wr_en, 0);
    chk("rst_din", u_if.din, 8'h00);
    chk("rst_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    rst = 1'b0;
    t_rdy = cyc;
    c0 = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (u_if.rdy_clr === 1'b1) begin
        c0 = cyc - t_rdy;
        break;
      end
    end
    chk("post_rst_clr_latency", c0, 1);
    u_if.rdy = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_rst_sent_n", sent_q.size(), 1);
    chk("post_rst_echo", sent_q.size() > 0 ? sent_q[0] : 8'hxx, 8'h42);

    for (int k = 0; k < 6; k++) begin
      base = sent_q.size();
      rx_byte(t2_in[k], 0);
      repeat (8) @(negedge clk);
      chk("echo_n", sent_q.size(), base + 1);
      if (sent_q.size() > base) begin
        chk("echo_byte", sent_q[base], t2_ex[k]);
        chk("wr_en_latency", wr_q[base] - t_rdy, 2);
      end
    end

    busy_mode = 1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 20; k++) rx_byte(t3_in[k], 0);
    chk("burst_count", fifo_count, 16);
    chk("burst_overflow", overflow, 1);
    chk("burst_drop_cnt", drop_cnt, 4);
    base = sent_q.size();
    busy_mode = 0;
    repeat (200) @(negedge clk);
    chk("burst_sent_n", sent_q.size(), base + 16);
    for (int k = 0; k < 16; k++)
      if (sent_q.size() > base + k) chk("burst_order", sent_q[base + k], t3_ex[k]);
    chk("burst_drained", fifo_count, 0);

    busy_mode = 1;
    repeat (2) @(negedge clk);
    c0 = clr_cnt;
    base = sent_q.size();
    rx_byte(8'h55, 5);
    chk("slow_rdy_count", fifo_count, 1);
    chk("slow_rdy_clr_pulses", clr_cnt - c0, 1);
    chk("overflow_sticky", overflow, 1);
    busy_mode = 0;
    repeat (20) @(negedge clk);
    chk("slow_rdy_sent_n", sent_q.size(), base + 1);
    chk("slow_rdy_byte", sent_q.size() > base ? sent_q[base] : 8'hxx, 8'h55);

    busy_mode = 2;
    repeat (2) @(negedge clk);
    base = sent_q.size();
    rx_byte(8'h31, 0);
    rx_byte(8'h32, 0);
    repeat (30) @(negedge clk);
    chk("timeout_sent_n", sent_q.size(), base + 2);
    if (sent_q.size() > base + 1) begin
      chk("timeout_byte0", sent_q[base], 8'h31);
      chk("timeout_byte1", sent_q[base + 1], 8'h32);
      chk("timeout_gap", wr_q[base + 1] - wr_q[base], 6);
    end

    busy_mode = 3;
    repeat (2) @(negedge clk);
    base = sent_q.size();
    for (int k = 0; k < 4; k++) rx_byte(8'h71 + 8'(k), 0);
    repeat (2) @(negedge clk);
    chk("wait_done_count", fifo_count, 3);
    chk("wait_done_sent_n", sent_q.size(), base + 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_drop_cnt", drop_cnt, 0);
    chk("mid_rst_din", u_if.din, 8'h00);
    chk("mid_rst_wr_en", u_if.wr_en, 0);
    rst = 1'b0;
    busy_mode = 0;
    repeat (30) @(negedge clk);
    chk("mid_rst_no_tx", sent_q.size(), base + 1);

    busy_mode = 1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 316; k++) begin
      rx_byte(8'(k), 0);
      if (k == 115) chk("drop_cnt_100", drop_cnt, 100);
      if (k == 269) chk("drop_cnt_254", drop_cnt, 8'hFE);
      if (k == 270) chk("drop_cnt_255", drop_cnt, 8'hFF);
    end
    chk("drop_cnt_sat", drop_cnt, 8'hFF);
    chk("sat_overflow", overflow, 1);
    chk("sat_count", fifo_count, 16);
    base = sent_q.size();
    busy_mode = 0;
    repeat (250) @(negedge clk);
    chk("sat_sent_n", sent_q.size(), base + 16);
    chk("sat_drained", fifo_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
